// File: rtl/shared_byte_arbiter_pkg.sv
// shared_byte_pkg: operation/state encodings and saturation limits for shared_byte_arbiter
package shared_byte_pkg;
    typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_ADD = 2'd2} op_e;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    localparam logic signed [7:0] SAT_MAX = 8'sd127;
    localparam logic signed [7:0] SAT_MIN = -8'sd128;
endpackage

// File: rtl/shared_byte_arbiter_if.sv
// shared_byte_arbiter_if: requester request bundle plus the common response channel
interface shared_byte_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0][1:0] req_op;
    logic [NUM_REQ-1:0][1:0] req_mask;
    logic [NUM_REQ-1:0][7:0] req_data;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [ID_W-1:0]         resp_id;
    logic signed [7:0]       resp_data;
    logic                    resp_sat;
    modport master (
        output req_valid, req_op, req_mask, req_data, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_sat
    );
    modport slave (
        input  req_valid, req_op, req_mask, req_data, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_sat
    );
endinterface

// File: rtl/shared_byte_arbiter_rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping modulo NUM_REQ
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);
    logic [ID_W-1:0] j;
    // scan farthest offset first so the nearest hit overwrites
    always_comb begin
        idx = '0;
        j = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (req[j]) idx = j;
        end
    end
    assign found = |req;
endmodule

// File: rtl/shared_byte_arbiter.sv
// shared_byte_arbiter: round-robin serialiser of read/lane-write/saturating-add ops on one shared signed byte
module shared_byte_arbiter
    import shared_byte_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    shared_byte_arbiter_if.slave bus,
    output logic signed [7:0] reg_q
);
    state_e            state;
    logic [ID_W-1:0]   ptr, win, lat_id;
    logic              found, sat;
    op_e               lat_op;
    logic [1:0]        lat_mask;
    logic signed [7:0] lat_data, wr_res, add_res, nxt;
    logic signed [8:0] sum;
    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req(bus.req_valid), .ptr(ptr), .found(found), .idx(win)
    );
    assign bus.req_ready = (rst_n && state == IDLE && found) ? NUM_REQ'(1) << win : '0;
    assign sum = {lat_data[7], lat_data} + {reg_q[7], reg_q};
    assign sat = sum[8] != sum[7];
    assign add_res = sat ? (sum[8] ? SAT_MIN : SAT_MAX) : sum[7:0];
    assign wr_res = {lat_mask[1] ? lat_data[7:4] : reg_q[7:4], lat_mask[0] ? lat_data[3:0] : reg_q[3:0]};
    assign nxt = lat_op == OP_WRITE ? wr_res : lat_op == OP_ADD ? add_res : reg_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= '0;
            reg_q          <= '0;
            lat_id         <= '0;
            lat_op         <= OP_READ;
            lat_mask       <= '0;
            lat_data       <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= '0;
            bus.resp_data  <= '0;
            bus.resp_sat   <= 1'b0;
        end else
            case (state)
                IDLE: if (found) begin
                    lat_id   <= win;
                    lat_op   <= bus.req_op[win] == 2'd3 ? OP_READ : op_e'(bus.req_op[win]);
                    lat_mask <= bus.req_mask[win];
                    lat_data <= bus.req_data[win];
                    ptr      <= win == ID_W'(NUM_REQ - 1) ? '0 : win + ID_W'(1);
                    state    <= EXEC;
                end
                EXEC: begin
                    reg_q          <= nxt;
                    bus.resp_data  <= nxt;
                    bus.resp_sat   <= lat_op == OP_ADD && sat;
                    bus.resp_id    <= lat_id;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
endmodule
